// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I controller:
// FSM states, opcodes, datapath select codes and fault causes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13,
        S_FAULT    = 4'd14
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_NOP   = 7'b0000000;

    localparam logic [1:0] SA_PC    = 2'b00;
    localparam logic [1:0] SA_OLDPC = 2'b01;
    localparam logic [1:0] SA_RS1   = 2'b10;
    localparam logic [1:0] SA_ZERO  = 2'b11;

    localparam logic [1:0] SB_RS2  = 2'b00;
    localparam logic [1:0] SB_IMM  = 2'b01;
    localparam logic [1:0] SB_FOUR = 2'b10;

    localparam logic [1:0] AO_ADD   = 2'b00;
    localparam logic [1:0] AO_BR    = 2'b01;
    localparam logic [1:0] AO_FUNCT = 2'b10;

    localparam logic [1:0] RS_ALUOUT = 2'b00;
    localparam logic [1:0] RS_RDATA  = 2'b01;
    localparam logic [1:0] RS_ALURES = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_ILLEGAL = 2'b10;

    function automatic logic is_mem_state(state_e s);
        return s inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
    endfunction

endpackage

// File: rtl/mc_main_fsm_if.sv
// Memory request/ready handshake between the main FSM and memory.
interface mc_main_fsm_if;

    logic mem_req;
    logic mem_ready;
    logic mem_write;
    logic adr_src;

    modport master (
        output mem_req,
        output mem_write,
        output adr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  adr_src,
        output mem_ready
    );

endinterface

// File: rtl/mc_imm_sel.sv
// Opcode to immediate-format select, purely combinational.
module mc_imm_sel
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        unique case (1'b1)
            op == OP_STORE:                 imm_src = IMM_S;
            op == OP_B:                     imm_src = IMM_B;
            op == OP_JAL:                   imm_src = IMM_J;
            op == OP_LUI || op == OP_AUIPC: imm_src = IMM_U;
            default:                        imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle RV32I main control FSM with memory stall timeout.
// Define ILLEGAL_OP_TRAP_EN to fault on unimplemented opcodes.
module mc_main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          op,
    mc_main_fsm_if.master       mem,
    output logic                ir_write,
    output logic                pc_update,
    output logic                reg_write,
    output logic                branch,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          result_src,
    output logic [2:0]          imm_src,
    output logic                instr_done,
    output logic                fault,
    output logic [1:0]          fault_cause
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         cause_q, cause_d;
    logic               rdy, timeout, nop_done;
    logic               req_r, wr_r, irw_r, pcu_r, rw_r, br_r, done_r;

    assign rdy     = mem.mem_ready;
    assign timeout = (MEM_TIMEOUT != 0) && !rdy
                   && (cnt_q == CNT_W'(MEM_TIMEOUT));

    mc_imm_sel u_imm_sel (
        .op      (op),
        .imm_src (imm_src)
    );

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        nop_done = 1'b0;
        unique case (state_q)
            S_FETCH:    if (rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:     state_d = S_EXECR;
                    OP_I:     state_d = S_EXECI;
                    OP_B:     state_d = S_BRANCH;
                    OP_JAL:   state_d = S_JAL;
                    OP_JALR:  state_d = S_JALR;
                    OP_LUI:   state_d = S_LUI;
                    OP_AUIPC: state_d = S_ALUWB;
                    OP_NOP: begin
                        state_d  = S_FETCH;
                        nop_done = 1'b1;
                    end
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        state_d = S_FAULT;
                        cause_d = FC_ILLEGAL;
`else
                        state_d  = S_FETCH;
                        nop_done = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (rdy) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (rdy) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_LUI:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_LINK;
            S_LINK:     state_d = S_ALUWB;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_FETCH;
        endcase
        if (is_mem_state(state_q) && timeout) begin
            state_d = S_FAULT;
            cause_d = FC_TIMEOUT;
        end
    end

    // Staying in a memory state means this cycle stalled.
    always_comb begin
        cnt_d = '0;
        if (is_mem_state(state_q) && state_d == state_q)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cause_q <= FC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        req_r       = 1'b0;
        wr_r        = 1'b0;
        irw_r       = 1'b0;
        pcu_r       = 1'b0;
        rw_r        = 1'b0;
        br_r        = 1'b0;
        done_r      = 1'b0;
        mem.adr_src = 1'b0;
        alu_src_a   = SA_PC;
        alu_src_b   = SB_RS2;
        alu_op      = AO_ADD;
        result_src  = RS_ALUOUT;
        unique case (state_q)
            S_FETCH: begin
                req_r      = 1'b1;
                irw_r      = rdy;
                pcu_r      = rdy;
                alu_src_b  = SB_FOUR;
                result_src = RS_ALURES;
            end
            S_DECODE: begin
                alu_src_a = SA_OLDPC;
                alu_src_b = SB_IMM;
                done_r    = nop_done;
            end
            S_MEMADR: begin
                alu_src_a = SA_RS1;
                alu_src_b = SB_IMM;
            end
            S_MEMREAD: begin
                req_r       = 1'b1;
                mem.adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RS_RDATA;
                rw_r       = 1'b1;
                done_r     = 1'b1;
            end
            S_MEMWRITE: begin
                req_r       = 1'b1;
                mem.adr_src = 1'b1;
                wr_r        = rdy;
                done_r      = rdy;
            end
            S_EXECR: begin
                alu_src_a = SA_RS1;
                alu_op    = AO_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SA_RS1;
                alu_src_b = SB_IMM;
                alu_op    = AO_FUNCT;
            end
            S_LUI: begin
                alu_src_a = SA_ZERO;
                alu_src_b = SB_IMM;
            end
            S_ALUWB: begin
                rw_r   = 1'b1;
                done_r = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SA_RS1;
                alu_op    = AO_BR;
                br_r      = 1'b1;
                done_r    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SA_OLDPC;
                alu_src_b = SB_FOUR;
                pcu_r     = 1'b1;
            end
            S_JALR: begin
                alu_src_a  = SA_RS1;
                alu_src_b  = SB_IMM;
                result_src = RS_ALURES;
                pcu_r      = 1'b1;
            end
            S_LINK: begin
                alu_src_a = SA_OLDPC;
                alu_src_b = SB_FOUR;
            end
            default: ;
        endcase
    end

    // Enables drop the moment reset asserts, ahead of the state flop.
    assign mem.mem_req   = req_r  & rst_n;
    assign mem.mem_write = wr_r   & rst_n;
    assign ir_write      = irw_r  & rst_n;
    assign pc_update     = pcu_r  & rst_n;
    assign reg_write     = rw_r   & rst_n;
    assign branch        = br_r   & rst_n;
    assign instr_done    = done_r & rst_n;
    assign fault         = (state_q == S_FAULT);
    assign fault_cause   = cause_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Randomized instruction stream checked cycle by cycle against a
// per-instruction step model of the multicycle controller.
module tb_mc_main_fsm;
    import riscv_ctrl_pkg::*;

    localparam int TMO = 15;

    localparam int P_RST  = 0;
    localparam int P_F    = 1;
    localparam int P_D    = 2;
    localparam int P_DN   = 3;
    localparam int P_MA   = 4;
    localparam int P_MR   = 5;
    localparam int P_MWB  = 6;
    localparam int P_MW   = 7;
    localparam int P_XR   = 8;
    localparam int P_XI   = 9;
    localparam int P_AWB  = 10;
    localparam int P_BR   = 11;
    localparam int P_JAL  = 12;
    localparam int P_JALR = 13;
    localparam int P_LINK = 14;
    localparam int P_LUI  = 15;
    localparam int P_FLT  = 16;

    // Only enables, done, fault and imm_src are defined while in reset.
    localparam logic [21:0] RST_MASK =
        {1'b1, 1'b0, 5'b11111, 8'h00, 1'b1, 1'b1, 2'b11, 3'b111};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic       ir_write, pc_update, reg_write, branch;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] imm_src;
    logic       instr_done, fault;
    logic [1:0] fault_cause;

    int total = 0;
    int bad = 0;
    int seq[$];

    mc_main_fsm_if m();

    mc_main_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .mem         (m),
        .ir_write    (ir_write),
        .pc_update   (pc_update),
        .reg_write   (reg_write),
        .branch      (branch),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .instr_done  (instr_done),
        .fault       (fault),
        .fault_cause (fault_cause)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == OP_STORE) return 3'b001;
        if (o == OP_B) return 3'b010;
        if (o == OP_JAL) return 3'b011;
        if (o == OP_LUI || o == OP_AUIPC) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic [21:0] expect_v(input int ph, input logic r,
                                             input logic [1:0] cause,
                                             input logic [6:0] o);
        logic req, adr, wr, irw, pcu, rw, br, dn, flt;
        logic [1:0] a, b, ao, rs, fc;
        {req, adr, wr, irw, pcu, rw, br, dn, flt} = '0;
        {a, b, ao, rs, fc} = '0;
        case (ph)
            P_F:    begin req = 1; b = 2; rs = 2; irw = r; pcu = r; end
            P_D:    begin a = 1; b = 1; end
            P_DN:   begin a = 1; b = 1; dn = 1; end
            P_MA:   begin a = 2; b = 1; end
            P_MR:   begin req = 1; adr = 1; end
            P_MWB:  begin rs = 1; rw = 1; dn = 1; end
            P_MW:   begin req = 1; adr = 1; wr = r; dn = r; end
            P_XR:   begin a = 2; ao = 2; end
            P_XI:   begin a = 2; b = 1; ao = 2; end
            P_AWB:  begin rw = 1; dn = 1; end
            P_BR:   begin a = 2; ao = 1; br = 1; dn = 1; end
            P_JAL:  begin a = 1; b = 2; pcu = 1; end
            P_JALR: begin a = 2; b = 1; rs = 2; pcu = 1; end
            P_LINK: begin a = 1; b = 2; end
            P_LUI:  begin a = 3; b = 1; end
            P_FLT:  begin flt = 1; fc = cause; end
            default: ;
        endcase
        return {req, adr, wr, irw, pcu, rw, br, a, b, ao, rs,
                dn, flt, fc, imm_of(o)};
    endfunction

    function automatic void build(input logic [6:0] o);
        case (o)
            OP_LOAD:  seq = '{P_F, P_D, P_MA, P_MR, P_MWB};
            OP_STORE: seq = '{P_F, P_D, P_MA, P_MW};
            OP_R:     seq = '{P_F, P_D, P_XR, P_AWB};
            OP_I:     seq = '{P_F, P_D, P_XI, P_AWB};
            OP_B:     seq = '{P_F, P_D, P_BR};
            OP_JAL:   seq = '{P_F, P_D, P_JAL, P_AWB};
            OP_JALR:  seq = '{P_F, P_D, P_JALR, P_LINK, P_AWB};
            OP_AUIPC: seq = '{P_F, P_D, P_AWB};
            OP_LUI:   seq = '{P_F, P_D, P_LUI, P_AWB};
            OP_NOP:   seq = '{P_F, P_DN};
`ifdef ILLEGAL_OP_TRAP_EN
            default:  seq = '{P_F, P_D, P_FLT};
`else
            default:  seq = '{P_F, P_DN};
`endif
        endcase
    endfunction

    function automatic logic [6:0] rand_op();
        logic [6:0] o;
        case ($urandom_range(0, 10))
            0: o = OP_LOAD;
            1: o = OP_STORE;
            2: o = OP_R;
            3: o = OP_I;
            4: o = OP_B;
            5: o = OP_JAL;
            6: o = OP_JALR;
            7: o = OP_AUIPC;
            8: o = OP_LUI;
            9: o = OP_NOP;
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                o = OP_R;
`else
                o = 7'($urandom);
                while (o inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_B, OP_JAL,
                                 OP_JALR, OP_AUIPC, OP_LUI})
                    o = 7'($urandom);
`endif
            end
        endcase
        return o;
    endfunction

    task automatic chk(input int ph, input logic r, input logic [1:0] cause,
                       input string tag);
        logic [21:0] e, o, mk;
        e = expect_v(ph, r, cause, op);
        o = {m.mem_req, m.adr_src, m.mem_write, ir_write, pc_update,
             reg_write, branch, alu_src_a, alu_src_b, alu_op, result_src,
             instr_done, fault, fault_cause, imm_src};
        mk = (ph == P_RST) ? RST_MASK : '1;
        total++;
        assert ((o & mk) === (e & mk))
        else begin
            bad++;
            $error("FAIL %s step=%0d op=%b observed=%h expected=%h",
                   tag, ph, op, o & mk, e & mk);
        end
    endtask

    task automatic cyc(input int ph, input logic r, input logic [6:0] o,
                       input logic [1:0] cause, input string tag);
        @(negedge clk);
        op = o;
        m.mem_ready = r;
        #1;
        chk(ph, r, cause, tag);
    endtask

    // fst/mst: stalls in FETCH / data memory steps, negative = random 0..3
    task automatic run_instr(input logic [6:0] o, input int fst,
                             input int mst, input string tag);
        int n;
        build(o);
        foreach (seq[i]) begin
            if (seq[i] == P_FLT) begin
                repeat (4) cyc(P_FLT, 1'($urandom_range(0, 1)), o,
                               FC_ILLEGAL, tag);
            end else if (seq[i] inside {P_F, P_MR, P_MW}) begin
                n = (seq[i] == P_F) ? fst : mst;
                if (n < 0) n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) cyc(seq[i], 1'b0, o, 2'b00, tag);
                cyc(seq[i], 1'b1, o, 2'b00, tag);
            end else begin
                cyc(seq[i], 1'($urandom_range(0, 1)), o, 2'b00, tag);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cyc(P_RST, 1'b1, op, 2'b00, "in_reset");
        cyc(P_RST, 1'b0, op, 2'b00, "in_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        m.mem_ready = 1'b0;
        do_reset();

        run_instr(OP_LOAD, 0, 0, "lw_zero_wait");
        run_instr(OP_STORE, 0, 3, "sw_3_wait");
        run_instr(OP_JALR, 0, 0, "jalr");
        run_instr(OP_LOAD, TMO, TMO, "lw_ready_on_timeout");
        run_instr(OP_NOP, 0, 0, "nop");

        repeat (150) run_instr(rand_op(), -1, -1, "random");

        cyc(P_F, 1'b1, OP_STORE, 2'b00, "sw_pre_rst");
        cyc(P_D, 1'b1, OP_STORE, 2'b00, "sw_pre_rst");
        cyc(P_MA, 1'b1, OP_STORE, 2'b00, "sw_pre_rst");
        cyc(P_MW, 1'b0, OP_STORE, 2'b00, "sw_pre_rst");
        #1 rst_n = 1'b0;
        m.mem_ready = 1'b1;
        #1 chk(P_RST, 1'b1, 2'b00, "rst_mid_memwrite");
        cyc(P_RST, 1'b1, OP_STORE, 2'b00, "rst_mid_memwrite");
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_instr(OP_R, 0, 0, "after_rst");

        run_instr(7'b1111111, 0, 0, "unimpl_op");

        do_reset();
        repeat (TMO + 1) cyc(P_F, 1'b0, OP_R, 2'b00, "fetch_stall");
        repeat (6) cyc(P_FLT, 1'($urandom_range(0, 1)), OP_R,
                       FC_TIMEOUT, "timeout_fault");

        do_reset();
        run_instr(OP_AUIPC, 0, 0, "recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
